lp_dma_seq: RTL and testbench
=============================

# lp_dma_seq

LP20 DMA sequencer: on a GO command it walks a buffer in KS10 memory, fetching 16-bit words over the bus-master handshake and splitting them into bytes for the printer datapath. It can also write words into the translation RAM. It owns the bus address register (BAR) and byte counter (BCTR) and reports completion and nonexistent-memory errors to the CSR logic. It sits between the LP20 CSR block, the bus-master interface, and the printer/translation-RAM datapath.

## Interface
Parameters:
- `AW`, 18, bus address width.
- `CW`, 12, byte counter width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `go`  in  1  single-cycle start pulse from CSRA.
- `abort`  in  1  level; cancels any transfer.
- `mode`  in  2  0=PRINT, 1=TEST, 2=DAVFU, 3=RAM; sampled on `go`.
- `bar_ld`  in  AW  start address; bit 0 ignored; loaded on `go`.
- `bctr_ld`  in  CW  byte count; loaded on `go`.
- `dma_req`  out  1  bus read request.
- `dma_addr`  out  AW  word address (bit 0 = 0).
- `dma_ack`  in  1  read complete; `dma_data` valid.
- `dma_nxm`  in  1  nonexistent memory; terminates the request.
- `dma_data`  in  16  read data.
- `byte_valid`  out  1  byte available (PRINT, DAVFU).
- `byte_davfu`  out  1  byte is DAVFU load data.
- `byte_data`  out  8  byte.
- `byte_ready`  in  1  consumer accepts the byte.
- `ram_wr`  out  1  translation-RAM write strobe.
- `ram_addr`  out  8  RAM word address.
- `ram_data`  out  12  `dma_data[11:0]`.
- `bar`  out  AW  current address.
- `bctr`  out  CW  remaining bytes.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err_nxm`  out  1  sticky NXM flag; cleared on `go`.

## Operation
- States: IDLE, FETCH, LOBYTE, HIBYTE, RAMWR, FINISH.
- IDLE, `go`=1:
  - Load `bar` = {`bar_ld[AW-1:1]`,0}, `bctr` = `bctr_ld`, mode; clear `err_nxm`, `ram_addr`.
  - If `bctr_ld`=0, go to FINISH; otherwise go to FETCH.
- `go` in any other state is ignored.
- FETCH:
  - Hold `dma_req`=1 and `dma_addr`=`bar` until `dma_ack` or `dma_nxm`.
  - On `dma_ack`: latch data, `bar` += 2 (wraps modulo 2^AW), then go to LOBYTE, or to RAMWR in RAM mode.
  - On `dma_nxm`: set `err_nxm`, go to FINISH.
  - If `dma_ack` and `dma_nxm` are both asserted, `dma_nxm` wins.
- LOBYTE / HIBYTE:
  - Present `data[7:0]` in LOBYTE and `data[15:8]` in HIBYTE.
  - A byte transfers when `byte_valid`&`byte_ready`; in TEST mode it transfers unconditionally with `byte_valid`=0.
  - Each transfer decrements `bctr`.
  - If `bctr` becomes 0, go to FINISH. Otherwise LOBYTE goes to HIBYTE, and HIBYTE goes to FETCH.
  - Odd count: the last word's high byte is never emitted.
  - `byte_davfu` = (mode==DAVFU) while `byte_valid`.
- RAMWR:
  - `ram_wr`=1 for one cycle, then `ram_addr`+=1 (wraps at 256).
  - `bctr` -= 2, saturating at 0.
  - If the result is 0, go to FINISH; otherwise go to FETCH.
- FINISH: `done`=1 for one cycle, then IDLE.
- `abort`=1 in any non-IDLE state: next state is IDLE and all strobes drop. No `done` is issued. `bar` and `bctr` keep their current values.
- Reset mid-transfer: immediate return to reset values; no `done`.

## Timing
- Reset values: state IDLE; `dma_req`, `byte_valid`, `byte_davfu`, `ram_wr`, `busy`, `done`, `err_nxm` = 0; `bar`, `bctr`, `dma_addr`, `byte_data`, `ram_addr`, `ram_data` = 0.
- `go` at cycle 0 gives `busy` and `dma_req` at cycle 1.
- `dma_ack` at cycle n gives `byte_valid` (or `ram_wr`) at cycle n+1.
- With `byte_ready` held high, one byte is accepted per cycle.
- After the last byte or RAM write, `done` is asserted the next cycle and `busy` drops the cycle after.
- Zero count: `go` at cycle 0 gives `done` at cycle 1 with no `dma_req`.
- All outputs are registered. `byte_data` is stable while `byte_valid`=1 and `byte_ready`=0.

## Test plan
- PRINT, `bar_ld`=0o1000, `bctr_ld`=3, words 0x4241 and 0x0043, `byte_ready`=1:
  - Expect bytes 0x41, 0x42, 0x43, then `done`.
  - Expect `bar`=0o1004, `bctr`=0, exactly 2 `dma_req` handshakes.
- Backpressure: hold `byte_ready`=0 for 5 cycles on the second byte.
  - `byte_data` stays 0x42 and `bctr` does not change until `byte_ready` is asserted.
- RAM mode, `bctr_ld`=6, words 0x1ABC, 0x0123, 0x0FFF:
  - Expect `ram_wr` ×3 with addr/data 0/0xABC, 1/0x123, 2/0xFFF, then `done`.
- NXM on the second FETCH:
  - Expect `err_nxm`=1, `done` pulse, and `bar` advanced by 2 only once.
  - Next `go` clears `err_nxm`.
- Edge cases:
  - `bctr_ld`=0 → `done` at cycle 1 with no `dma_req`.
  - `bar_ld`=0x3FFFE → `bar` wraps to 0x00000 after the first fetch.
  - `abort` during FETCH → `dma_req` low the next cycle, no `done`.
- TEST mode, `bctr_ld`=4: `byte_valid` stays 0, and `done` comes 2 cycles after the second `dma_ack`.

Source files
------------

// File: rtl/lp_dma_seq.sv
// -----------------------------------------------------------------------------
// lp_dma_seq -- LP20 DMA sequencer
//
// Walks a buffer in KS10 memory on a GO command. Each 16-bit word is fetched
// over the bus-master handshake, then either split into two bytes for the
// printer datapath (PRINT / TEST / DAVFU) or written as one 12-bit entry into
// the translation RAM (RAM mode). Owns the bus address register (BAR) and the
// byte counter (BCTR), and reports completion and nonexistent-memory errors
// back to the CSR logic.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   go              single-cycle start pulse (honoured only when idle)
//   abort           level; cancels any transfer in progress
//   mode            0=PRINT 1=TEST 2=DAVFU 3=RAM, sampled on go
//   bar_ld/bctr_ld  start address (bit 0 ignored) and byte count, loaded on go
//   dma_*           bus-master read handshake (req/addr out, ack/nxm/data in)
//   byte_*          byte stream to the printer datapath (valid/ready)
//   ram_*           translation-RAM write port
//   bar, bctr       current address and remaining byte count
//   busy, done      activity level and one-cycle completion pulse
//   err_nxm         sticky nonexistent-memory flag, cleared on go
// -----------------------------------------------------------------------------
module lp_dma_seq #(
    parameter int AW = 18,
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] bar_ld,
    input  logic [CW-1:0] bctr_ld,
    output logic          dma_req,
    output logic [AW-1:0] dma_addr,
    input  logic          dma_ack,
    input  logic          dma_nxm,
    input  logic [15:0]   dma_data,
    output logic          byte_valid,
    output logic          byte_davfu,
    output logic [7:0]    byte_data,
    input  logic          byte_ready,
    output logic          ram_wr,
    output logic [7:0]    ram_addr,
    output logic [11:0]   ram_data,
    output logic [AW-1:0] bar,
    output logic [CW-1:0] bctr,
    output logic          busy,
    output logic          done,
    output logic          err_nxm
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOBYTE,
        S_HIBYTE,
        S_RAMWR,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        M_PRINT = 2'd0,
        M_TEST  = 2'd1,
        M_DAVFU = 2'd2,
        M_RAM   = 2'd3
    } mode_t;

    state_t        state_q, state_d;
    mode_t         mode_q, mode_d;
    logic [AW-1:0] bar_q, bar_d;
    logic [CW-1:0] bctr_q, bctr_d;
    logic [7:0]    hi_byte_q, hi_byte_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic [7:0]    ram_addr_q, ram_addr_d;
    logic [11:0]   ram_data_q, ram_data_d;
    logic          err_nxm_q, err_nxm_d;

    logic          dma_req_q;
    logic          byte_valid_q;
    logic          byte_davfu_q;
    logic          ram_wr_q;
    logic          busy_q;
    logic          done_q;

    logic          xfer;
    logic          byte_state_d;

    // TEST mode drains bytes at one per cycle without presenting them.
    assign xfer = (mode_q == M_TEST) || (byte_valid_q && byte_ready);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned -- otherwise synthesis infers a latch.
        state_d     = state_q;
        mode_d      = mode_q;
        bar_d       = bar_q;
        bctr_d      = bctr_q;
        hi_byte_d   = hi_byte_q;
        byte_data_d = byte_data_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        err_nxm_d   = err_nxm_q;

        if (abort && (state_q != S_IDLE)) begin
            // Cancel: drop back to idle, leave BAR/BCTR where they stopped.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        // Masking keeps all of bar_ld in use while forcing an even address.
                        bar_d      = bar_ld & ~AW'(1);
                        bctr_d     = bctr_ld;
                        mode_d     = mode_t'(mode);
                        err_nxm_d  = 1'b0;
                        ram_addr_d = '0;
                        state_d    = (bctr_ld == '0) ? S_FINISH : S_FETCH;
                    end
                end

                S_FETCH: begin
                    // NXM takes priority over a simultaneous ack.
                    if (dma_nxm) begin
                        err_nxm_d = 1'b1;
                        state_d   = S_FINISH;
                    end else if (dma_ack) begin
                        bar_d       = bar_q + AW'(2);
                        hi_byte_d   = dma_data[15:8];
                        byte_data_d = dma_data[7:0];
                        ram_data_d  = dma_data[11:0];
                        state_d     = (mode_q == M_RAM) ? S_RAMWR : S_LOBYTE;
                    end
                end

                S_LOBYTE: begin
                    if (xfer) begin
                        bctr_d = bctr_q - CW'(1);
                        if (bctr_q == CW'(1)) begin
                            state_d = S_FINISH;     // odd count: high byte dropped
                        end else begin
                            state_d     = S_HIBYTE;
                            byte_data_d = hi_byte_q;
                        end
                    end
                end

                S_HIBYTE: begin
                    if (xfer) begin
                        bctr_d  = bctr_q - CW'(1);
                        state_d = (bctr_q == CW'(1)) ? S_FINISH : S_FETCH;
                    end
                end

                S_RAMWR: begin
                    ram_addr_d = ram_addr_q + 8'd1;
                    if (bctr_q <= CW'(2)) begin
                        bctr_d  = '0;
                        state_d = S_FINISH;
                    end else begin
                        bctr_d  = bctr_q - CW'(2);
                        state_d = S_FETCH;
                    end
                end

                S_FINISH: state_d = S_IDLE;

                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with it.
    assign byte_state_d = (state_d == S_LOBYTE) || (state_d == S_HIBYTE);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= M_PRINT;
            bar_q        <= '0;
            bctr_q       <= '0;
            hi_byte_q    <= '0;
            byte_data_q  <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            err_nxm_q    <= 1'b0;
            dma_req_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_davfu_q <= 1'b0;
            ram_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values; blocking would chain updates within one edge.
            state_q      <= state_d;
            mode_q       <= mode_d;
            bar_q        <= bar_d;
            bctr_q       <= bctr_d;
            hi_byte_q    <= hi_byte_d;
            byte_data_q  <= byte_data_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            err_nxm_q    <= err_nxm_d;
            dma_req_q    <= (state_d == S_FETCH);
            byte_valid_q <= byte_state_d && (mode_d != M_TEST);
            byte_davfu_q <= byte_state_d && (mode_d == M_DAVFU);
            ram_wr_q     <= (state_d == S_RAMWR);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_FINISH);
        end
    end

    assign dma_req    = dma_req_q;
    assign dma_addr   = bar_q;      // BAR is always even and is the fetch address
    assign byte_valid = byte_valid_q;
    assign byte_davfu = byte_davfu_q;
    assign byte_data  = byte_data_q;
    assign ram_wr     = ram_wr_q;
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign bar        = bar_q;
    assign bctr       = bctr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_nxm    = err_nxm_q;

endmodule

// File: tb/tb_lp_dma_seq.sv
// -----------------------------------------------------------------------------
// tb_lp_dma_seq -- directed self-checking bench for lp_dma_seq.
// Inputs are driven and outputs sampled on the falling clock edge, so each
// tick() advances exactly one rising edge of the design.
// -----------------------------------------------------------------------------
module tb_lp_dma_seq;

    localparam int AW = 18;
    localparam int CW = 12;

    localparam logic [1:0] PRINT = 2'd0;
    localparam logic [1:0] TEST  = 2'd1;
    localparam logic [1:0] DAVFU = 2'd2;
    localparam logic [1:0] RAM   = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go;
    logic          abort;
    logic [1:0]    mode;
    logic [AW-1:0] bar_ld;
    logic [CW-1:0] bctr_ld;
    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic          dma_ack;
    logic          dma_nxm;
    logic [15:0]   dma_data;
    logic          byte_valid;
    logic          byte_davfu;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          ram_wr;
    logic [7:0]    ram_addr;
    logic [11:0]   ram_data;
    logic [AW-1:0] bar;
    logic [CW-1:0] bctr;
    logic          busy;
    logic          done;
    logic          err_nxm;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int hs_base;

    lp_dma_seq #(.AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .abort      (abort),
        .mode       (mode),
        .bar_ld     (bar_ld),
        .bctr_ld    (bctr_ld),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_ack    (dma_ack),
        .dma_nxm    (dma_nxm),
        .dma_data   (dma_data),
        .byte_valid (byte_valid),
        .byte_davfu (byte_davfu),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .bar        (bar),
        .bctr       (bctr),
        .busy       (busy),
        .done       (done),
        .err_nxm    (err_nxm)
    );

    always #5 clk = ~clk;

    // Bus handshakes completed (request high and terminated on the same edge).
    always @(posedge clk) begin
        if (dma_req && (dma_ack || dma_nxm)) hs_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] m, input logic [AW-1:0] a, input logic [CW-1:0] n);
        mode    = m;
        bar_ld  = a;
        bctr_ld = n;
        go      = 1'b1;
        tick();
        go      = 1'b0;
    endtask

    // Wait (bounded) for a request, check its address, answer it for one edge.
    task automatic serve(input string tag, input logic [15:0] data, input logic nxm,
                         input logic [AW-1:0] exp_addr);
        int guard = 0;
        while (dma_req !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check({tag, "_req"}, 32'(dma_req), 32'd1);
        check({tag, "_addr"}, 32'(dma_addr), 32'(exp_addr));
        dma_data = data;
        dma_ack  = ~nxm;
        dma_nxm  = nxm;
        tick();
        dma_ack  = 1'b0;
        dma_nxm  = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        go         = 1'b0;
        abort      = 1'b0;
        mode       = PRINT;
        bar_ld     = '0;
        bctr_ld    = '0;
        dma_ack    = 1'b0;
        dma_nxm    = 1'b0;
        dma_data   = '0;
        byte_ready = 1'b1;
        tick();
        tick();

        // ---- reset values ----
        check("rst_busy", 32'(busy), 0);
        check("rst_req", 32'(dma_req), 0);
        check("rst_valid", 32'(byte_valid), 0);
        check("rst_ramwr", 32'(ram_wr), 0);
        check("rst_done", 32'(done), 0);
        check("rst_nxm", 32'(err_nxm), 0);
        check("rst_bar", 32'(bar), 0);
        check("rst_bctr", 32'(bctr), 0);
        check("rst_bdata", 32'(byte_data), 0);
        rst_n = 1'b1;
        tick();

        // ---- PRINT, 3 bytes from 0o1000 ----
        hs_base = hs_cnt;
        start(PRINT, 18'o1000, 12'd3);
        check("p_busy", 32'(busy), 1);
        check("p_req", 32'(dma_req), 1);
        serve("p_w0", 16'h4241, 1'b0, 18'o1000);
        check("p_b0_valid", 32'(byte_valid), 1);
        check("p_b0", 32'(byte_data), 32'h41);
        check("p_b0_req", 32'(dma_req), 0);
        tick();
        check("p_b1", 32'(byte_data), 32'h42);
        check("p_b1_bctr", 32'(bctr), 2);
        tick();
        check("p_bctr1", 32'(bctr), 1);
        serve("p_w1", 16'h0043, 1'b0, 18'o1002);
        check("p_b2", 32'(byte_data), 32'h43);
        check("p_b2_valid", 32'(byte_valid), 1);
        tick();
        check("p_done", 32'(done), 1);
        check("p_bar", 32'(bar), 32'o1004);
        check("p_bctr0", 32'(bctr), 0);
        check("p_valid_off", 32'(byte_valid), 0);
        tick();
        check("p_done_pulse", 32'(done), 0);
        check("p_idle", 32'(busy), 0);
        check("p_handshakes", 32'(hs_cnt - hs_base), 2);

        // ---- backpressure on the second byte ----
        start(PRINT, 18'o2000, 12'd3);
        serve("bp_w0", 16'h4241, 1'b0, 18'o2000);
        check("bp_b0", 32'(byte_data), 32'h41);
        tick();
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data", 32'(byte_data), 32'h42);
            check("bp_hold_valid", 32'(byte_valid), 1);
            check("bp_hold_bctr", 32'(bctr), 2);
            tick();
        end
        byte_ready = 1'b1;
        tick();
        check("bp_bctr_after", 32'(bctr), 1);
        serve("bp_w1", 16'h0043, 1'b0, 18'o2002);
        check("bp_b2", 32'(byte_data), 32'h43);
        tick();
        check("bp_done", 32'(done), 1);
        tick();

        // ---- RAM mode, 3 words ----
        start(RAM, 18'o3000, 12'd6);
        serve("r_w0", 16'h1ABC, 1'b0, 18'o3000);
        check("r0_wr", 32'(ram_wr), 1);
        check("r0_addr", 32'(ram_addr), 0);
        check("r0_data", 32'(ram_data), 32'hABC);
        check("r0_novalid", 32'(byte_valid), 0);
        tick();
        check("r0_wr_pulse", 32'(ram_wr), 0);
        check("r0_bctr", 32'(bctr), 4);
        serve("r_w1", 16'h0123, 1'b0, 18'o3002);
        check("r1_addr", 32'(ram_addr), 1);
        check("r1_data", 32'(ram_data), 32'h123);
        tick();
        serve("r_w2", 16'h0FFF, 1'b0, 18'o3004);
        check("r2_wr", 32'(ram_wr), 1);
        check("r2_addr", 32'(ram_addr), 2);
        check("r2_data", 32'(ram_data), 32'hFFF);
        tick();
        check("r_done", 32'(done), 1);
        check("r_bctr", 32'(bctr), 0);
        tick();

        // ---- NXM on second fetch ----
        start(PRINT, 18'o4000, 12'd4);
        serve("n_w0", 16'h1111, 1'b0, 18'o4000);
        tick();
        tick();
        serve("n_w1", 16'h2222, 1'b1, 18'o4002);
        check("n_err", 32'(err_nxm), 1);
        check("n_done", 32'(done), 1);
        check("n_bar", 32'(bar), 32'o4002);
        check("n_req_off", 32'(dma_req), 0);
        tick();
        check("n_sticky", 32'(err_nxm), 1);
        check("n_idle", 32'(busy), 0);

        // ---- zero count (also clears err_nxm) ----
        hs_base = hs_cnt;
        start(PRINT, 18'o500, 12'd0);
        check("z_done", 32'(done), 1);
        check("z_req", 32'(dma_req), 0);
        check("z_err_clr", 32'(err_nxm), 0);
        tick();
        check("z_idle", 32'(busy), 0);
        check("z_no_hs", 32'(hs_cnt - hs_base), 0);

        // ---- address wrap; bit 0 of bar_ld ignored ----
        start(PRINT, 18'h3FFFF, 12'd2);
        check("w_bar", 32'(bar), 32'h3FFFE);
        serve("w_w0", 16'hA55A, 1'b0, 18'h3FFFE);
        check("w_bar_wrap", 32'(bar), 0);
        check("w_b0", 32'(byte_data), 32'h5A);
        tick();
        check("w_b1", 32'(byte_data), 32'hA5);
        tick();
        check("w_done", 32'(done), 1);
        tick();

        // ---- abort during FETCH ----
        start(PRINT, 18'o5000, 12'd4);
        check("a_req", 32'(dma_req), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("a_req_off", 32'(dma_req), 0);
        check("a_busy", 32'(busy), 0);
        check("a_no_done", 32'(done), 0);
        check("a_bar", 32'(bar), 32'o5000);
        check("a_bctr", 32'(bctr), 4);
        tick();
        check("a_no_done2", 32'(done), 0);

        // ---- TEST mode: bytes drained silently, one per cycle ----
        start(TEST, 18'o6000, 12'd4);
        serve("t_w0", 16'h1234, 1'b0, 18'o6000);
        check("t_novalid", 32'(byte_valid), 0);
        tick();
        tick();
        check("t_bctr", 32'(bctr), 2);
        serve("t_w1", 16'h5678, 1'b0, 18'o6002);
        check("t_no_done_a", 32'(done), 0);
        tick();
        check("t_no_done_b", 32'(done), 0);
        tick();
        check("t_done", 32'(done), 1);
        check("t_bctr0", 32'(bctr), 0);
        check("t_novalid_end", 32'(byte_valid), 0);
        tick();

        // ---- DAVFU, odd count of 1: high byte never emitted ----
        start(DAVFU, 18'o7000, 12'd1);
        serve("d_w0", 16'h9977, 1'b0, 18'o7000);
        check("d_valid", 32'(byte_valid), 1);
        check("d_davfu", 32'(byte_davfu), 1);
        check("d_byte", 32'(byte_data), 32'h77);
        tick();
        check("d_done", 32'(done), 1);
        check("d_valid_off", 32'(byte_valid), 0);
        check("d_davfu_off", 32'(byte_davfu), 0);
        tick();

        // ---- reset mid-transfer ----
        start(PRINT, 18'o1000, 12'd4);
        serve("x_w0", 16'hBEEF, 1'b0, 18'o1000);
        #2 rst_n = 1'b0;
        #1;
        check("x_busy", 32'(busy), 0);
        check("x_valid", 32'(byte_valid), 0);
        check("x_bar", 32'(bar), 0);
        check("x_bctr", 32'(bctr), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("x_no_done", 32'(done), 0);
        check("x_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
